// File: rtl/apb_i2c_bridge.sv
// APB3 slave bridging single-byte commands to an I2C master, plus local status.
// Optional BUSY watchdog built when APB_I2C_TIMEOUT_EN is defined.
module apb_i2c_bridge #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [8:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  output logic       i2c_ce,
  output logic [7:0] i2c_addr,
  output logic [7:0] i2c_wdata,
  output logic       i2c_rden,
  output logic       i2c_wren,
  input  logic [7:0] i2c_rdata,
  input  logic       i2c_done,
  input  logic       i2c_error
);

  typedef enum logic [1:0] {
    IDLE, BUSY, RESP, LOCAL
  } state_t;

  state_t state, state_nx;
  logic             err_q, err_nx;
  logic [7:0]       rdata_q;
  logic             local_wr;
  logic [CNT_W-1:0] cnt;
  logic             sticky_err;
  logic             timeout_flag;
  logic             wd_hit;
  logic             setup;
  logic             unused_cnt;

  assign setup      = psel && !penable;
  assign unused_cnt = ^cnt;

`ifdef APB_I2C_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ?
                        $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_MAX =
    WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wdog;

  assign wd_hit = (state == BUSY) && (wdog == WD_MAX);

  // Held at zero outside BUSY, so every BUSY entry starts from 0
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog         <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (state == BUSY) wdog <= wdog + 1'b1;
      else               wdog <= '0;
      if (wd_hit && !i2c_done && !i2c_error)
        timeout_flag <= 1'b1;
      else if (state == LOCAL && local_wr)
        timeout_flag <= 1'b0;
    end
  end
`else
  assign wd_hit       = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    err_nx   = err_q;
    unique case (state)
      IDLE:
        if (setup) state_nx = paddr[8] ? LOCAL : BUSY;
      BUSY:
        if (i2c_error) begin
          state_nx = RESP;
          err_nx   = 1'b1;
        end else if (i2c_done) begin
          state_nx = RESP;
          err_nx   = 1'b0;
        end else if (wd_hit) begin
          state_nx = RESP;
          err_nx   = 1'b1;
        end
      RESP:    state_nx = IDLE;
      LOCAL:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      local_wr   <= 1'b0;
      cnt        <= '0;
      sticky_err <= 1'b0;
      i2c_addr   <= '0;
      i2c_wdata  <= '0;
      i2c_rden   <= 1'b0;
      i2c_wren   <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      if (state == IDLE && setup) begin
        if (!paddr[8]) begin
          i2c_addr  <= paddr[7:0];
          i2c_wdata <= pwdata;
          i2c_wren  <= pwrite;
          i2c_rden  <= !pwrite;
          rdata_q   <= '0;
        end else begin
          local_wr  <= pwrite;
        end
      end
      if (state == BUSY && i2c_done && !i2c_error && i2c_rden)
        rdata_q <= i2c_rdata;
      if (state == BUSY && state_nx == RESP) begin
        if (err_nx) sticky_err <= 1'b1;
        else        cnt        <= cnt + 1'b1;
      end
      if (state == LOCAL && local_wr)
        sticky_err <= 1'b0;
    end
  end

  assign i2c_ce  = (state == BUSY);
  assign pready  = (state == RESP) || (state == LOCAL);
  assign pslverr = (state == RESP) && err_q;

  always_comb begin
    prdata = '0;
    if (state == RESP && i2c_rden && !err_q)
      prdata = rdata_q;
    else if (state == LOCAL && !local_wr)
      prdata = {sticky_err, timeout_flag, cnt[5:0]};
  end

endmodule
